// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arb_pkg
//  Purpose  : Shared types and constants for the two-port RAM arbiter.
//             Holds the sequencer state encoding and the fixed response
//             latencies, counted in cycles from the handshake edge.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package ram_arb_pkg;

   // Sequencer states. Each RAM access runs through a fixed path:
   // writes take IDLE->WR, reads take IDLE->RD->RD_CAP.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WR     = 2'd1,
      RD     = 2'd2,
      RD_CAP = 2'd3
   } arb_state_t;

   // Number of cycles from the handshake edge until the cycle in which
   // rsp_valid is high.
   localparam int RD_LAT = 3;
   localparam int WR_LAT = 2;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-way round-robin grant logic, purely combinational.
//             A lone request is granted directly. When both requesters ask,
//             the one that was not granted last time wins. The last-grant
//             history is held by the parent.
//  Ports    : i_req        [1:0] request bits, bit i = requester i
//             i_last_grant       index of the requester granted last
//             o_grant      [1:0] one-hot grant (all zero if no request)
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_last_grant,
   output logic [1:0] o_grant
);

   always_comb begin
      o_grant = 2'b00;
      case (i_req)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         // Contention: the requester that was not served last time wins.
         2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
         default: o_grant = 2'b00;
      endcase
   end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_port_arbiter
//  Purpose  : Shares one single-port RAM between two requesters. It uses
//             round-robin arbitration and runs one access at a time. It owns
//             the tristate drive of the RAM data bus, and it returns a
//             completion pulse (plus read data) to the requester that issued
//             the access.
//  Ports    : clk, rst                 clock, async active-high reset
//             req_valid/req_ready [1:0] per-requester handshake
//             req_we    [1:0]           1 = write, 0 = read
//             req_addr  [2*ADDRWIDTH]   requester i at [i*ADDRWIDTH +: ADDRWIDTH]
//             req_wdata [2*DATAWIDTH]   requester i at [i*DATAWIDTH +: DATAWIDTH]
//             rsp_valid [1:0]           one-cycle completion pulse
//             rsp_rdata [DATAWIDTH]     last captured read data (shared)
//             ram_addr/ram_data/ram_cs/ram_we/ram_oe  RAM pins
//  Revision : 1.0  initial release
// ============================================================================
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDRWIDTH = 4,
   parameter int DATAWIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               req_valid,
   output logic [1:0]               req_ready,
   input  logic [1:0]               req_we,
   input  logic [2*ADDRWIDTH-1:0]   req_addr,
   input  logic [2*DATAWIDTH-1:0]   req_wdata,
   output logic [1:0]               rsp_valid,
   output logic [DATAWIDTH-1:0]     rsp_rdata,
   output logic [ADDRWIDTH-1:0]     ram_addr,
   inout  wire  [DATAWIDTH-1:0]     ram_data,
   output logic                     ram_cs,
   output logic                     ram_we,
   output logic                     ram_oe
);

   arb_state_t                r_state;
   arb_state_t                w_state_nxt;
   logic                      r_last_grant;
   logic                      r_idx;
   logic [ADDRWIDTH-1:0]      r_addr;
   logic [DATAWIDTH-1:0]      r_wdata;
   logic [DATAWIDTH-1:0]      r_rdata;
   logic [1:0]                r_rsp_valid;

   logic [1:0]                w_grant;
   logic [1:0]                w_ready;
   logic                      w_accept;
   logic                      w_sel;
   logic                      w_cs;
   logic                      w_we;
   logic                      w_oe;
   logic                      w_drive;
   logic                      w_done;

   rr_arb2 u_rr_arb2 (
      .i_req        (req_valid),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant)
   );

   // Index of the granted requester. It is only meaningful when a grant exists.
   assign w_sel = w_grant[1];

   // ---------------------------------------------------------------------
   // Next-state and RAM pin decode
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 2'b00;
      w_accept    = 1'b0;
      w_cs        = 1'b0;
      w_we        = 1'b0;
      w_oe        = 1'b0;
      w_drive     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            // Accept is the same as the grant: the grant is only non-zero
            // where the matching valid bit is set.
            w_ready  = w_grant;
            w_accept = |w_grant;
            if (w_accept) begin
               w_state_nxt = req_we[w_sel] ? WR : RD;
            end
         end
         WR: begin
            w_cs        = 1'b1;
            w_we        = 1'b1;
            w_drive     = 1'b1;
            w_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         RD: begin
            w_cs        = 1'b1;
            w_oe        = 1'b1;
            w_state_nxt = RD_CAP;
         end
         RD_CAP: begin
            // The RAM is now driving the word it registered at the end of RD.
            w_cs        = 1'b1;
            w_oe        = 1'b1;
            w_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // State, latched request, response registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_idx        <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rdata      <= '0;
         r_rsp_valid  <= 2'b00;
      end else begin
         r_state <= w_state_nxt;

         if (w_accept) begin
            r_idx        <= w_sel;
            r_last_grant <= w_sel;
            r_addr       <= w_sel ? req_addr[2*ADDRWIDTH-1:ADDRWIDTH]
                                  : req_addr[ADDRWIDTH-1:0];
            r_wdata      <= w_sel ? req_wdata[2*DATAWIDTH-1:DATAWIDTH]
                                  : req_wdata[DATAWIDTH-1:0];
         end

         if (r_state == RD_CAP) begin
            r_rdata <= ram_data;
         end

         // The completion pulse lands in the IDLE cycle that follows WR
         // or RD_CAP and is routed only to the issuer.
         r_rsp_valid <= w_done ? (r_idx ? 2'b10 : 2'b01) : 2'b00;
      end
   end

   // While reset is held, the state is IDLE but nothing may be accepted.
   assign req_ready = rst ? 2'b00 : w_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rdata;

   assign ram_addr  = r_addr;
   assign ram_cs    = w_cs;
   assign ram_we    = w_we;
   assign ram_oe    = w_oe;

   // The arbiter drives the data bus only in WR. In WR, ram_oe is low, so
   // the RAM never drives at the same time.
   assign ram_data  = w_drive ? r_wdata : {DATAWIDTH{1'bz}};

endmodule : ram_port_arbiter
`default_nettype wire
